// File: rtl/stream_cipher_core.sv
// LFSR keystream cipher: XORs each accepted word with a Galois-LFSR keystream word.
// Optional STREAM_CIPHER_WORDCOUNT_EN adds a 32-bit accepted-word counter port.
module stream_cipher_core #(
    parameter int unsigned        DATA_W = 8,
    parameter int unsigned        LFSR_W = 32,
    parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(32'h8020_0003),
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(32'hACE1_2468),
    parameter int unsigned        WARMUP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              key_load,
    input  logic [LFSR_W-1:0] key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef STREAM_CIPHER_WORDCOUNT_EN
    ,
    output logic [31:0]       word_count
`endif
);

    localparam int unsigned       CNT_W     = 8;
    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr,      w_lfsr_nxt;
    logic [CNT_W-1:0]    r_warm_cnt,  w_warm_cnt_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
    logic [31:0]         r_word_count, w_word_count_nxt;
`endif

    logic [LFSR_W-1:0]   w_lfsr_step;
    logic [LFSR_W-1:0]   w_key_state;
    logic                w_in_ready;
    logic                w_transfer;

    // One keystream word = DATA_W single-bit Galois shifts.
    function automatic logic [LFSR_W-1:0] lfsr_word_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
        end
        return v;
    endfunction

    assign w_lfsr_step = lfsr_word_step(r_lfsr);
    assign w_key_state = (key_in == '0) ? SEED : key_in;
    assign w_in_ready  = ena && (r_state == S_RUN) && !key_load && (!r_out_valid || out_ready);
    assign w_transfer  = in_valid && w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state == S_WARMUP);
`ifdef STREAM_CIPHER_WORDCOUNT_EN
    assign word_count = r_word_count;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= SEED;
            r_warm_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
            r_word_count <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_warm_cnt   <= w_warm_cnt_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
            r_word_count <= w_word_count_nxt;
`endif
        end
    end

    // Key load wins over everything; otherwise the state decides what steps the LFSR.
    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = r_lfsr;
        w_warm_cnt_nxt   = r_warm_cnt;
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
        w_word_count_nxt = r_word_count;
`endif
        if (ena) begin
            if (key_load) begin
                w_lfsr_nxt       = w_key_state;
                w_warm_cnt_nxt   = '0;
                w_out_valid_nxt  = 1'b0;
                w_state_nxt      = (WARMUP == 0) ? S_RUN : S_WARMUP;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
                w_word_count_nxt = '0;
`endif
            end else begin
                case (r_state)
                    S_WARMUP: begin
                        w_lfsr_nxt     = w_lfsr_step;
                        w_warm_cnt_nxt = r_warm_cnt + CNT_W'(1);
                        if (r_warm_cnt == WARM_LAST) begin
                            w_state_nxt    = S_RUN;
                            w_warm_cnt_nxt = '0;
                        end
                    end
                    S_RUN: begin
                        if (w_transfer) begin
                            w_out_data_nxt   = in_data ^ r_lfsr[DATA_W-1:0];
                            w_out_valid_nxt  = 1'b1;
                            w_lfsr_nxt       = w_lfsr_step;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
                            w_word_count_nxt = r_word_count + 32'd1;
`endif
                        end else if (out_ready) begin
                            w_out_valid_nxt = 1'b0;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_cipher_core.sv
// Self-checking bench for stream_cipher_core against a transaction-level keystream model.
module tb_stream_cipher_core;

    localparam logic [31:0] TAPS_M = 32'h8020_0003;
    localparam logic [31:0] SEED_M = 32'hACE1_2468;
    localparam int          WARM   = 4;

    logic        clk;
    logic        rst;
    logic        ena, key_load, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] key_in;
    logic [7:0]  in_data, out_data;

    logic        z_ena, z_key_load, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
    logic [31:0] z_key_in;
    logic [7:0]  z_in_data, z_out_data;
`ifdef STREAM_CIPHER_WORDCOUNT_EN
    logic [31:0] word_count, z_word_count;
`endif

    int          n_vec;
    int          n_err;
    logic [31:0] m_lfsr;
    int unsigned m_count;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  plain[16];
    logic [7:0]  cipher[16];
    logic [7:0]  kdummy;

    stream_cipher_core u_dut (
        .clk(clk), .rst(rst), .ena(ena), .key_load(key_load), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef STREAM_CIPHER_WORDCOUNT_EN
        , .word_count(word_count)
`endif
    );

    stream_cipher_core #(.WARMUP(0)) u_dut_nowarm (
        .clk(clk), .rst(rst), .ena(z_ena), .key_load(z_key_load), .key_in(z_key_in),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .busy(z_busy)
`ifdef STREAM_CIPHER_WORDCOUNT_EN
        , .word_count(z_word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keystream word is the low byte before eight single-bit Galois shifts.
    task automatic model_take(output logic [7:0] k);
        k = m_lfsr[7:0];
        for (int i = 0; i < 8; i++) begin
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ TAPS_M;
            else           m_lfsr = m_lfsr >> 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input bit iv, input logic [7:0] d, input bit ordy);
        logic [7:0] k;
        bit         exp_rdy;
        ena = 1'b1; key_load = 1'b0; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
        exp_rdy = (exp_q.size() == 0) || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef STREAM_CIPHER_WORDCOUNT_EN
        check("word_count", word_count, m_count);
`endif
        if (ordy && exp_q.size() != 0) begin
            got_q.push_back(out_data);
            void'(exp_q.pop_front());
        end
        if (iv && exp_rdy) begin
            model_take(k);
            exp_q.push_back(d ^ k);
            m_count++;
        end
        tick();
    endtask

    task automatic load_key(input logic [31:0] k);
        ena = 1'b1; key_load = 1'b1; key_in = k; in_valid = 1'b1;
        in_data = 8'($urandom); out_ready = 1'b1;
        #1;
        check("in_ready_during_load", 32'(in_ready), 32'd0);
        tick();
        key_load = 1'b0;
        m_lfsr = (k == 32'd0) ? SEED_M : k;
        exp_q.delete();
        m_count = 0;
        check("out_valid_after_load", 32'(out_valid), 32'd0);
`ifdef STREAM_CIPHER_WORDCOUNT_EN
        check("word_count_after_load", word_count, 32'd0);
`endif
        for (int i = 0; i < WARM; i++) begin
            #1;
            check("busy_warmup", 32'(busy), 32'd1);
            check("in_ready_warmup", 32'(in_ready), 32'd0);
            model_take(kdummy);
            tick();
        end
        check("busy_after_warmup", 32'(busy), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_count = 0; m_lfsr = SEED_M;
        rst = 1'b1;
        ena = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        z_ena = 1'b0; z_key_load = 1'b0; z_key_in = '0; z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_nowarm_out_valid", 32'(z_out_valid), 32'd0);
        rst = 1'b0;
        tick();

        // IDLE ignores input without a key.
        ena = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        tick();

        // WARMUP=0 instance: key A5 ^ FF = 5A one cycle after the transfer.
        z_ena = 1'b1; z_key_load = 1'b1; z_key_in = 32'h0000_00A5;
        tick();
        z_key_load = 1'b0; z_in_valid = 1'b1; z_in_data = 8'hFF; z_out_ready = 1'b1;
        #1;
        check("nowarm_busy", 32'(z_busy), 32'd0);
        check("nowarm_in_ready", 32'(z_in_ready), 32'd1);
        tick();
        z_in_valid = 1'b0;
        check("nowarm_out_valid", 32'(z_out_valid), 32'd1);
        check("nowarm_out_data", 32'(z_out_data), 32'h5A);

        // Zero key behaves as SEED.
        load_key(32'd0);
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 8'($urandom), 1'b1);
        run_cycle(1'b0, 8'h00, 1'b1);

        // Encrypt 16 words, then decrypt with the same key.
        load_key(32'h1234_5678);
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            plain[i] = 8'($urandom);
            run_cycle(1'b1, plain[i], 1'b1);
        end
        run_cycle(1'b0, 8'h00, 1'b1);
        check("ct_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) cipher[i] = (i < got_q.size()) ? got_q[i] : 8'h00;
        load_key(32'h1234_5678);
        got_q.delete();
        for (int i = 0; i < 16; i++) run_cycle(1'b1, cipher[i], 1'b1);
        run_cycle(1'b0, 8'h00, 1'b1);
        check("pt_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) check("roundtrip", 32'(got_q[i]), 32'(plain[i]));

        // Backpressure for 5 cycles, then 1 word/cycle.
        run_cycle(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 8'($urandom), 1'b1);

        // Global enable low freezes everything with a word pending.
        for (int i = 0; i < 3; i++) begin
            ena = 1'b0; in_valid = 1'b1; out_ready = 1'b1; key_load = 1'b0;
            #1;
            check("ena0_in_ready", 32'(in_ready), 32'd0);
            check("ena0_out_valid", 32'(out_valid), 32'd1);
            check("ena0_out_data", 32'(out_data), 32'(exp_q[0]));
            check("ena0_busy", 32'(busy), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'($urandom), 1'b1);

        // Random traffic under a fresh key loaded while a word is pending.
        run_cycle(1'b1, 8'($urandom), 1'b0);
        load_key($urandom | 32'd1);
        for (int i = 0; i < 150; i++)
            run_cycle(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(2) != 0));

        // Asynchronous reset with a word pending.
        run_cycle(1'b1, 8'($urandom), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
`ifdef STREAM_CIPHER_WORDCOUNT_EN
        check("midrst_word_count", word_count, 32'd0);
`endif
        tick();
        rst = 1'b0;
        exp_q.delete(); m_lfsr = SEED_M; m_count = 0;
        for (int i = 0; i < 3; i++) begin
            ena = 1'b1; in_valid = 1'b1; out_ready = 1'b1; key_load = 1'b0;
            #1;
            check("postrst_in_ready", 32'(in_ready), 32'd0);
            check("postrst_out_valid", 32'(out_valid), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
            tick();
        end

        load_key(32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 8'($urandom), ($urandom_range(1) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
